// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX; grant+tx_start 1 clk after req in IDLE, requesters stall until granted.
// Optional UART_ARB_LOCK_EN adds lock[] so a locked owner keeps the transmitter for contiguous multi-byte messages.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int GAP_CYCLES   = 2,
    parameter int BUSY_TIMEOUT = 16,
    parameter int PTR_WIDTH    = 3
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]            lock,
`endif
    input  logic                          tx_busy,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          tx_start,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic [PTR_WIDTH-1:0]          owner,
    output logic                          arb_busy,
    output logic                          err_timeout
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 2);

    typedef enum logic [2:0] {IDLE, START, WAIT_HI, WAIT_LO, GAP} state_t;

    state_t                  state_q;
    logic [NUM_REQ-1:0]      gnt_q;
    logic                    tx_start_q;
    logic [DATA_WIDTH-1:0]   tx_data_q;
    logic [PTR_WIDTH-1:0]    owner_q;
    logic                    arb_busy_q;
    logic                    err_timeout_q;
    logic [TW-1:0]           to_cnt_q;
    logic [GW-1:0]           gap_cnt_q;

    logic [PTR_WIDTH-1:0]    winner_d;
    logic [DATA_WIDTH-1:0]   sel_dat_d;
    logic [NUM_REQ-1:0]      sel_gnt_d;
    int                      best_dist;
    int                      cand_dist;

`ifdef UART_ARB_LOCK_EN
    logic                    lock_skip_q;
    logic                    keep_d;
`endif

    // Distance from owner+1 (mod NUM_REQ) ranks requesters; the nearest active one wins.
    always_comb begin
        best_dist = NUM_REQ;
        cand_dist = 0;
        winner_d  = owner_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_dist = (i + NUM_REQ - int'(owner_q) - 1) % NUM_REQ;
            if (req[i] && cand_dist < best_dist) begin
                best_dist = cand_dist;
                winner_d  = PTR_WIDTH'(i);
            end
        end
`ifdef UART_ARB_LOCK_EN
        keep_d = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == PTR_WIDTH'(i)) keep_d = lock[i] & req[i];
        end
        if (keep_d && !lock_skip_q) winner_d = owner_q;
`endif
        sel_dat_d = '0;
        sel_gnt_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner_d == PTR_WIDTH'(i)) begin
                sel_dat_d    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_gnt_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            owner_q       <= PTR_WIDTH'(NUM_REQ - 1);
            arb_busy_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            to_cnt_q      <= '0;
            gap_cnt_q     <= '0;
`ifdef UART_ARB_LOCK_EN
            lock_skip_q   <= 1'b0;
`endif
        end else begin
            gnt_q      <= '0;
            tx_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req && !tx_busy) begin
                        gnt_q      <= sel_gnt_d;
                        tx_start_q <= 1'b1;
                        tx_data_q  <= sel_dat_d;
                        owner_q    <= winner_d;
                        arb_busy_q <= 1'b1;
                        state_q    <= START;
`ifdef UART_ARB_LOCK_EN
                        lock_skip_q <= 1'b0;
`endif
                    end
                end
                START: begin
                    to_cnt_q <= '0;
                    state_q  <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (tx_busy) begin
                        state_q <= WAIT_LO;
                    end else if (to_cnt_q == TW'(BUSY_TIMEOUT - 1)) begin
                        // Byte is dropped; a locked owner loses its claim too.
                        err_timeout_q <= 1'b1;
                        gap_cnt_q     <= GW'(GAP_CYCLES);
                        state_q       <= GAP;
`ifdef UART_ARB_LOCK_EN
                        lock_skip_q   <= 1'b1;
`endif
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        gap_cnt_q <= GW'(GAP_CYCLES);
                        state_q   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == '0) begin
                        arb_busy_q <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign owner       = owner_q;
    assign arb_busy    = arb_busy_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random request traffic against a round-robin reference model.
module tb_uart_tx_arbiter;
    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int GAP = 2;
    localparam int BTO = 16;
    localparam int PW  = 3;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic            tx_busy;
    logic            busy_m;
    logic            busy_force;
    logic [N-1:0]    gnt;
    logic            tx_start;
    logic [DW-1:0]   tx_data;
    logic [PW-1:0]   owner;
    logic            arb_busy;
    logic            err_timeout;
`ifdef UART_ARB_LOCK_EN
    logic [N-1:0]    lock;
    logic [N-1:0]    lock_edge;
`endif

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .GAP_CYCLES(GAP),
                      .BUSY_TIMEOUT(BTO), .PTR_WIDTH(PW)) dut (
        .clk(clk), .rstn(rstn), .req(req), .req_data(req_data),
`ifdef UART_ARB_LOCK_EN
        .lock(lock),
`endif
        .tx_busy(tx_busy), .gnt(gnt), .tx_start(tx_start), .tx_data(tx_data),
        .owner(owner), .arb_busy(arb_busy), .err_timeout(err_timeout));

    always #5 clk = ~clk;
    assign tx_busy = busy_m | busy_force;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [N-1:0] req_edge;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        req_edge <= req;
`ifdef UART_ARB_LOCK_EN
        lock_edge <= lock;
`endif
    end

    // Transmitter model: busy rises one clock after tx_start and stays high busy_len clocks.
    bit tx_never = 1'b0;
    int busy_len = 20;
    int fall_cyc = -1;
    initial begin
        busy_m = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (tx_start && !tx_never) begin
                @(posedge clk); #1;
                busy_m = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1;
                busy_m   = 1'b0;
                fall_cyc = cyc;
            end
        end
    end

    // Reference model state
    int            left [N];
    logic [DW-1:0] cur_byte [N];
    int            exp_owner;
    bit            lock_skip;
    logic [N-1:0]  prev_gnt;
    logic [DW-1:0] last_tx;
    int            order [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic present(input int i, input logic [DW-1:0] b, input int n);
        left[i]                 = n;
        cur_byte[i]             = b;
        req_data[i*DW +: DW]    = b;
        req[i]                  = 1'b1;
    endtask

    task automatic reset_model();
        exp_owner = N - 1;
        lock_skip = 1'b0;
        prev_gnt  = '0;
        last_tx   = '0;
        for (int i = 0; i < N; i++) begin
            left[i] = 0;
            req[i]  = 1'b0;
        end
    endtask

    // Expected winner: locked owner if still locked and requesting, else first requester after the last one served.
    function automatic int model_pick();
`ifdef UART_ARB_LOCK_EN
        if (!lock_skip && lock_edge[exp_owner] && req_edge[exp_owner]) return exp_owner;
`endif
        for (int k = 1; k <= N; k++) begin
            if (req_edge[(exp_owner + k) % N]) return (exp_owner + k) % N;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // One clock: sample at negedge, check against the model, then refill or drop the granted requester.
    task automatic tick();
        int w;
        int e;
        @(negedge clk);
        if (rstn) begin
            check("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
            check("start_vs_gnt", 32'(tx_start), 32'(|gnt));
            if (gnt != '0) begin
                w = onehot_idx(gnt);
                e = model_pick();
                check("gnt_pulse", 32'(prev_gnt), 32'd0);
                check("rr_winner", w, e);
                check("tx_data", 32'(tx_data), 32'(cur_byte[w]));
                check("owner", 32'(owner), w);
                if (fall_cyc >= 0) check("gap_after_busy", 32'((cyc - fall_cyc) >= GAP), 32'd1);
                order.push_back(w);
                exp_owner = w;
                lock_skip = 1'b0;
                last_tx   = cur_byte[w];
                if (left[w] > 1) present(w, 8'($urandom), left[w] - 1);
                else begin
                    left[w] = 0;
                    req[w]  = 1'b0;
                end
            end else if (arb_busy) begin
                check("tx_data_hold", 32'(tx_data), 32'(last_tx));
            end
            prev_gnt = gnt;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        tick();
        while (n < 1000 && !(req == '0 && !arb_busy && !tx_busy)) begin
            tick();
            n++;
        end
        check("idle_reached", 32'(n < 1000), 32'd1);
    endtask

    task automatic wait_gnt(output int w);
        int n = 0;
        w = -1;
        while (n < 200 && w < 0) begin
            tick();
            if (gnt != '0) w = onehot_idx(gnt);
            n++;
        end
        check("gnt_seen", 32'(w >= 0), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        reset_model();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic check_order(input string tag, input int exp_q [$]);
        check({tag, "_len"}, order.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < order.size(); i++)
            check(tag, order[i], exp_q[i]);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rstn       = 1'b0;
        req        = '0;
        req_data   = '0;
        busy_force = 1'b0;
`ifdef UART_ARB_LOCK_EN
        lock       = '0;
`endif
        reset_model();
        #12;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_owner", 32'(owner), N - 1);
        check("rst_arb_busy", 32'(arb_busy), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Single requester, byte 0x41: granted on the first clock after req.
        tick();
        present(0, 8'h41, 1);
        tick();
        check("t1_gnt", 32'(gnt), 32'b0001);
        check("t1_start", 32'(tx_start), 32'd1);
        check("t1_data", 32'(tx_data), 32'h41);
        check("t1_owner", 32'(owner), 32'd0);
        tick();
        check("t1_arb_busy", 32'(arb_busy), 32'd1);
        check("t1_start_pulse", 32'(tx_start), 32'd0);
        wait_idle();

        // All four requesting and refilled from reset: 0,1,2,3,0.
        do_reset();
        order.delete();
        tick();
        present(0, 8'($urandom), 2);
        for (int i = 1; i < N; i++) present(i, 8'($urandom), 1);
        wait_idle();
        check_order("rr_all", '{0, 1, 2, 3, 0});

        // Move owner to 2, then 0101 wraps past 3 to 0, then 2.
        order.delete();
        present(2, 8'($urandom), 1);
        wait_idle();
        check("owner_is_2", 32'(owner), 32'd2);
        present(0, 8'($urandom), 1);
        present(2, 8'($urandom), 1);
        wait_idle();
        check_order("rr_wrap", '{2, 0, 2});

        // Transmitter busy while IDLE blocks any grant.
        busy_force = 1'b1;
        present(1, 8'($urandom), 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("busy_blocks_gnt", 32'(gnt), 32'd0);
        end
        busy_force = 1'b0;
        wait_gnt(w);
        check("busy_release_gnt", w, 32'd1);
        wait_idle();

        // Random traffic with varying frame lengths.
        for (int r = 0; r < 25; r++) begin
            busy_len = $urandom_range(1, 6);
            for (int i = 0; i < N; i++)
                if (left[i] == 0 && $urandom_range(0, 1) == 1)
                    present(i, 8'($urandom), $urandom_range(1, 3));
            repeat ($urandom_range(0, 12)) tick();
        end
        wait_idle();

        // Transmitter never answers: fault after BUSY_TIMEOUT clocks in WAIT_HI, byte dropped.
        busy_len = 20;
        tx_never = 1'b1;
        present(2, 8'($urandom), 1);
        wait_gnt(w);
        repeat (BTO) tick();
        check("timeout_not_yet", 32'(err_timeout), 32'd0);
        tick();
        check("timeout_set", 32'(err_timeout), 32'd1);
        lock_skip = 1'b1;
        tx_never  = 1'b0;
        wait_idle();
        check("timeout_back_idle", 32'(arb_busy), 32'd0);
        present(3, 8'($urandom), 1);
        wait_gnt(w);
        check("after_timeout_gnt", w, 32'd3);
        check("err_sticky", 32'(err_timeout), 32'd1);

        // Asynchronous reset in WAIT_LO.
        wait_idle();
        present(1, 8'($urandom), 1);
        wait_gnt(w);
        repeat (5) tick();
        check("pre_rst_busy", 32'({arb_busy, tx_busy}), 32'b11);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_gnt", 32'(gnt), 32'd0);
        check("arst_tx_start", 32'(tx_start), 32'd0);
        check("arst_tx_data", 32'(tx_data), 32'd0);
        check("arst_owner", 32'(owner), N - 1);
        check("arst_arb_busy", 32'(arb_busy), 32'd0);
        check("arst_err", 32'(err_timeout), 32'd0);
        reset_model();
        for (int k = 0; k < 100 && busy_m; k++) @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        present(1, 8'($urandom), 1);
        wait_gnt(w);
        check("post_rst_owner", 32'(owner), 32'd1);
        wait_idle();

`ifdef UART_ARB_LOCK_EN
        // Locked requester 0 keeps the transmitter for its 3 bytes, then 1 is served.
        order.delete();
        lock = 4'b0001;
        present(0, 8'($urandom), 3);
        present(1, 8'($urandom), 1);
        wait_idle();
        lock = '0;
        check_order("lock_order", '{0, 0, 0, 1});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
